rv_uart_loader: RTL and testbench
=================================

RV_UART_LOADER -- requirements
Module: rv_uart_loader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning clk_i frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning UART bit rate; BIT_CLKS = CLK_FREQ/BAUD_RATE clocks per bit.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  input  1  system clock, all logic on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 uart_rx  input  1  serial input, 8N1, LSB first, idle high.
REQ-007 uart_tx  output  1  serial status output, 8N1.
REQ-008 data_req_o  output  1  memory request (initiator side of the core data memory interface).
REQ-009 data_we_o  output  1  write enable.
REQ-010 data_be_o  output  XLEN/8  byte enables.
REQ-011 data_addr_o  output  XLEN  byte address.
REQ-012 data_wdata_o  output  XLEN  write data.
REQ-013 data_rvalid_i  input  1  request completion from memory.
REQ-014 data_rdata_i  input  XLEN  read data, unused.
REQ-015 cpu_rst_o  output  1  holds the core in reset while loading.
REQ-016 done_o  output  1  one-cycle pulse when a load completes.
REQ-017 err_o  output  1  one-cycle pulse on framing error.

Function
REQ-018 RX SHALL pass uart_rx through a 2-flop synchronizer and detect a high-to-low edge only while the receiver is idle.
REQ-019 RX SHALL wait BIT_CLKS/2 clocks, then re-sample; a high sample is a false start, so RX returns to idle with no byte and no error.
REQ-020 RX SHALL then sample 8 data bits and the stop bit, each BIT_CLKS clocks apart, with data assembled LSB first.
REQ-021 A stop bit sampled low SHALL discard the byte, pulse err_o, and return the loader FSM to S_ADDR with its byte counter cleared.
REQ-022 The loader FSM SHALL have the states S_ADDR, S_LEN, S_DATA, S_WRITE and S_DONE, and SHALL reset into S_ADDR.
REQ-023 S_ADDR SHALL collect 4 bytes little-endian into the base address, force bits [1:0] to 0, then go to S_LEN.
REQ-024 S_LEN SHALL collect 4 bytes little-endian into the word count; count 0 goes to S_DONE, otherwise to S_DATA.
REQ-025 S_DATA SHALL collect 4 bytes little-endian into data_wdata_o, then go to S_WRITE.
REQ-026 In S_WRITE, data_req_o, data_we_o=1 and data_be_o=all ones SHALL be held with addr and wdata stable until data_rvalid_i is sampled high; data_rvalid_i in the first request cycle is valid.
REQ-027 On rvalid, the FSM SHALL deassert data_req_o the next cycle, add 4 to the address (wrap modulo 2^XLEN), and decrement the count; it goes to S_DONE if the count becomes 0, else to S_DATA.
REQ-028 S_DONE SHALL pulse done_o for one cycle, clear cpu_rst_o, and return to S_ADDR.
REQ-029 cpu_rst_o SHALL be 1 from reset until the first done_o, and again from the first S_ADDR byte of each later load until its done_o.
REQ-030 Bytes completing while in S_WRITE SHALL be held in a one-byte holding register; a second byte arriving while it is full SHALL be handled as a framing error per REQ-021.
REQ-031 data_req_o, data_we_o and data_be_o SHALL be 0 outside S_WRITE.

Reset
REQ-032 Reset SHALL set: data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0, cpu_rst_o=1, done_o=0, err_o=0, uart_tx=1, FSM=S_ADDR, RX idle, holding register empty.
REQ-033 Reset asserted mid-transfer SHALL abandon any request immediately; data_req_o SHALL be 0 in the cycle after rst_i is sampled high.

Configuration
REQ-034 With macro UART_LOADER_ACK_EN defined, TX SHALL send 0x06 after each done_o and 0x15 after each err_o, 8N1 at BIT_CLKS clocks per bit.
REQ-035 With UART_LOADER_ACK_EN defined, a status request arriving while TX is busy SHALL be dropped.
REQ-036 Without UART_LOADER_ACK_EN, uart_tx SHALL be constant 1 and no TX logic SHALL be built.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000)
REQ-037 Bytes 00 10 00 00, 02 00 00 00, 78 56 34 12, EF BE AD DE -> writes 0x12345678@0x1000 then 0xDEADBEEF@0x1004, be=F, then done_o pulse and cpu_rst_o falls.
REQ-038 Memory model holding rvalid low for 20 cycles -> req, addr and wdata stay stable all 20 cycles; req low the cycle after rvalid.
REQ-039 Third address byte sent with stop bit 0 -> err_o pulse, no memory request; a following valid 8-byte header with count 0 -> done_o and no writes.
REQ-040 2-clock low glitch on uart_rx while idle -> no byte, no err_o, FSM unchanged.
REQ-041 Address 0x0000_1003, count 1 -> write to 0x1000; address 0xFFFF_FFFC, count 2 -> writes to 0xFFFF_FFFC then 0x0000_0000.
REQ-042 With UART_LOADER_ACK_EN defined, after REQ-037 -> uart_tx carries 0x06; after REQ-039's error -> uart_tx carries 0x15.

Source files
------------

// File: rtl/rv_uart_loader_if.sv
// Core data-memory bus between the UART loader (initiator) and memory (target).
// Target holds data_rvalid_i low to stall; the initiator keeps the request stable meanwhile.
interface rv_uart_loader_if #(
    parameter int XLEN = 32
);
    logic                data_req_o;
    logic                data_we_o;
    logic [XLEN/8-1:0]   data_be_o;
    logic [XLEN-1:0]     data_addr_o;
    logic [XLEN-1:0]     data_wdata_o;
    logic                data_rvalid_i;
    logic [XLEN-1:0]     data_rdata_i;

    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/rv_uart_loader.sv
// UART boot loader: receives addr/len/data words (LE, 8N1) and writes them to memory, holding the core in reset.
// Writes stall until data_rvalid_i; optional ACK/NAK status byte on uart_tx when UART_LOADER_ACK_EN is defined.
module rv_uart_loader #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int XLEN      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              uart_rx,
    output logic              uart_tx,
    rv_uart_loader_if.master  mem,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int CW       = $clog2(BIT_CLKS) + 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [2:0] {S_ADDR, S_LEN, S_DATA, S_WRITE, S_DONE} state_e;

    // ---------------- receiver ----------------
    logic [2:0]    rx_sync_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_vld_q, rx_vld_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic          rx_s, rx_prev;

    // [1] is the synchronized line, [2] its previous value for edge detection
    assign rx_s    = rx_sync_q[1];
    assign rx_prev = rx_sync_q[2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_sync_q  <= 3'b111;
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_vld_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[1:0], uart_rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_vld_q   <= rx_vld_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_vld_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_d = R_START;
                    rx_cnt_d   = CW'(BIT_CLKS / 2 - 1);
                end
            end
            R_START: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end else if (rx_s) begin
                    rx_state_d = R_IDLE;
                end else begin
                    rx_state_d = R_DATA;
                    rx_cnt_d   = CW'(BIT_CLKS - 1);
                    rx_bit_d   = '0;
                end
            end
            R_DATA: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end else begin
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    rx_cnt_d   = CW'(BIT_CLKS - 1);
                    if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
                end
            end
            default: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end else begin
                    rx_state_d = R_IDLE;
                    rx_vld_d   = rx_s;
                    rx_ferr_d  = !rx_s;
                end
            end
        endcase
    end

    // ---------------- loader ----------------
    state_e          state_q, state_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] len_q, len_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            hold_vld_q, hold_vld_d;
    logic [7:0]      hold_dat_q, hold_dat_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            take, overrun;
    logic [XLEN-1:0] len_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_ADDR;
            bcnt_q     <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            hold_vld_q <= 1'b0;
            hold_dat_q <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            hold_vld_q <= hold_vld_d;
            hold_dat_q <= hold_dat_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Every received byte lands in the holding register; collecting states drain it next cycle
    assign take     = hold_vld_q && (state_q inside {S_ADDR, S_LEN, S_DATA});
    assign overrun  = rx_vld_q && hold_vld_q && !take;
    assign len_next = {hold_dat_q, len_q[XLEN-1:8]};

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        hold_vld_d = hold_vld_q;
        hold_dat_d = hold_dat_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (take) hold_vld_d = 1'b0;
        if (rx_vld_q) begin
            hold_vld_d = 1'b1;
            hold_dat_d = rx_shift_q;
        end
        case (state_q)
            S_ADDR: if (take) begin
                addr_d = {hold_dat_q, addr_q[XLEN-1:8]};
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == 2'd0) cpu_rst_d = 1'b1;
                if (bcnt_q == 2'd3) begin
                    addr_d[1:0] = 2'b00;
                    state_d     = S_LEN;
                end
            end
            S_LEN: if (take) begin
                len_d  = len_next;
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == 2'd3) state_d = (len_next == '0) ? S_DONE : S_DATA;
            end
            S_DATA: if (take) begin
                wdata_d = {hold_dat_q, wdata_q[XLEN-1:8]};
                bcnt_d  = bcnt_q + 1'b1;
                if (bcnt_q == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: if (mem.data_rvalid_i) begin
                addr_d  = addr_q + XLEN'(4);
                len_d   = len_q - 1'b1;
                state_d = (len_q == XLEN'(1)) ? S_DONE : S_DATA;
            end
            S_DONE: begin
                done_d    = 1'b1;
                cpu_rst_d = 1'b0;
                state_d   = S_ADDR;
            end
            default: state_d = S_ADDR;
        endcase
        if (rx_ferr_q || overrun) begin
            err_d      = 1'b1;
            state_d    = S_ADDR;
            bcnt_d     = '0;
            hold_vld_d = 1'b0;
        end
    end

    assign mem.data_req_o   = (state_q == S_WRITE);
    assign mem.data_we_o    = (state_q == S_WRITE);
    assign mem.data_be_o    = {(XLEN/8){state_q == S_WRITE}};
    assign mem.data_addr_o  = addr_q;
    assign mem.data_wdata_o = wdata_q;
    assign cpu_rst_o        = cpu_rst_q;
    assign done_o           = done_q;
    assign err_o            = err_q;

`ifdef UART_LOADER_ACK_EN
    logic          tx_busy_q;
    logic [9:0]    tx_shift_q;
    logic [3:0]    tx_bits_q;
    logic [CW-1:0] tx_cnt_q;

    // Status requests that arrive while a frame is in flight are dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_bits_q  <= '0;
            tx_cnt_q   <= '0;
        end else if (!tx_busy_q) begin
            if (done_q || err_q) begin
                tx_busy_q  <= 1'b1;
                tx_shift_q <= {1'b1, (done_q ? 8'h06 : 8'h15), 1'b0};
                tx_bits_q  <= '0;
                tx_cnt_q   <= CW'(BIT_CLKS - 1);
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
        end else begin
            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            tx_cnt_q   <= CW'(BIT_CLKS - 1);
            tx_bits_q  <= tx_bits_q + 1'b1;
            if (tx_bits_q == 4'd9) tx_busy_q <= 1'b0;
        end
    end

    assign uart_tx = tx_busy_q ? tx_shift_q[0] : 1'b1;
`else
    assign uart_tx = 1'b1;
`endif
endmodule

// File: tb/tb_rv_uart_loader.sv
// Directed bench for rv_uart_loader at 1 MHz / 100 kbaud (10 clocks per bit) with a stalling memory model.
module tb_rv_uart_loader;
    localparam int BIT = 10;

    logic clk = 1'b0;
    logic rst;
    logic uart_rx;
    logic uart_tx;
    logic cpu_rst, done, err;

    always #5 clk = ~clk;

    rv_uart_loader_if #(.XLEN(32)) bus ();

    rv_uart_loader #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .XLEN(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .mem       (bus.master),
        .cpu_rst_o (cpu_rst),
        .done_o    (done),
        .err_o     (err)
    );

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int mem_delay = 0;
    int wait_cnt = 0;
    int last_wait = -1;
    int stable_err = 0;
    int req_late = 0;
    logic [31:0] a0, d0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  wb_q[$];
    logic [7:0]  tx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = stop;
        repeat (BIT) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic wait_done(input int n, input string tag);
        for (int i = 0; i < 300 && done_cnt < n; i++) @(negedge clk);
        check(tag, done_cnt, n);
    endtask

    // Pulse counters (a stretched pulse counts more than once)
    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    // Memory: answers each request after mem_delay low-rvalid cycles and checks stability
    initial begin
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (bus.data_rvalid_i) begin
                bus.data_rvalid_i = 1'b0;
                if (bus.data_req_o) req_late++;
                wait_cnt = 0;
            end else if (bus.data_req_o) begin
                if (wait_cnt == 0) begin
                    a0 = bus.data_addr_o;
                    d0 = bus.data_wdata_o;
                end else if (bus.data_addr_o !== a0 || bus.data_wdata_o !== d0) begin
                    stable_err++;
                end
                if (wait_cnt == mem_delay) begin
                    bus.data_rvalid_i = 1'b1;
                    last_wait = wait_cnt;
                    wa_q.push_back(bus.data_addr_o);
                    wd_q.push_back(bus.data_wdata_o);
                    wb_q.push_back(bus.data_we_o ? bus.data_be_o : 4'h0);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Status-byte decoder on uart_tx
    initial forever begin
        logic [7:0] b;
        @(negedge clk);
        if (uart_tx === 1'b0) begin
            repeat (15) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                b[i] = uart_tx;
                repeat (BIT) @(negedge clk);
            end
            tx_q.push_back(b);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", bus.data_req_o, 0);
        check("rst_we", bus.data_we_o, 0);
        check("rst_be", bus.data_be_o, 0);
        check("rst_addr", bus.data_addr_o, 0);
        check("rst_wdata", bus.data_wdata_o, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_tx", uart_tx, 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Two-word load, immediate acknowledge
        send_word(32'h0000_1000);
        check("l1_cpu_rst_loading", cpu_rst, 1);
        send_word(32'h0000_0002);
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        wait_done(1, "l1_done");
        check("l1_nwrites", wa_q.size(), 2);
        check("l1_addr0", wa_q[0], 32'h0000_1000);
        check("l1_data0", wd_q[0], 32'h1234_5678);
        check("l1_be0", wb_q[0], 4'hF);
        check("l1_addr1", wa_q[1], 32'h0000_1004);
        check("l1_data1", wd_q[1], 32'hDEAD_BEEF);
        check("l1_be1", wb_q[1], 4'hF);
        check("l1_cpu_rst", cpu_rst, 0);
        check("l1_err", err_cnt, 0);
        check("l1_req_late", req_late, 0);
`ifdef UART_LOADER_ACK_EN
        repeat (150) @(negedge clk);
        check("l1_ack", tx_q.size() > 0 ? tx_q[tx_q.size()-1] : 8'hXX, 8'h06);
`endif

        // Stalling memory: 20 cycles with rvalid low
        mem_delay = 20;
        send_word(32'h0000_2000);
        check("l2_cpu_rst_reasserted", cpu_rst, 1);
        send_word(32'h0000_0001);
        send_word(32'hA5A5_5A5A);
        wait_done(2, "l2_done");
        check("l2_nwrites", wa_q.size(), 3);
        check("l2_addr", wa_q[2], 32'h0000_2000);
        check("l2_data", wd_q[2], 32'hA5A5_5A5A);
        check("l2_wait", last_wait, 20);
        check("l2_stable", stable_err, 0);
        check("l2_req_late", req_late, 0);
        mem_delay = 0;

        // Framing error on third address byte, then an empty load
        send_byte(8'h00, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (5) @(negedge clk);
        check("fe_err", err_cnt, 1);
        check("fe_nwrites", wa_q.size(), 3);
        check("fe_req", bus.data_req_o, 0);
`ifdef UART_LOADER_ACK_EN
        repeat (150) @(negedge clk);
        check("fe_nak", tx_q.size() > 0 ? tx_q[tx_q.size()-1] : 8'hXX, 8'h15);
`endif
        send_word(32'h0000_4000);
        send_word(32'h0000_0000);
        wait_done(3, "fe_done_after");
        check("fe_nowrites_after", wa_q.size(), 3);
        check("fe_cpu_rst", cpu_rst, 0);

        // Two-clock glitch must not start a byte
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        check("gl_err", err_cnt, 1);
        check("gl_cpu_rst", cpu_rst, 0);

        // Misaligned base, then address wrap
        send_word(32'h0000_1003);
        send_word(32'h0000_0001);
        send_word(32'h1122_3344);
        wait_done(4, "al_done");
        check("al_addr", wa_q[3], 32'h0000_1000);
        check("al_data", wd_q[3], 32'h1122_3344);
        send_word(32'hFFFF_FFFC);
        send_word(32'h0000_0002);
        send_word(32'hCAFE_0001);
        send_word(32'hCAFE_0002);
        wait_done(5, "wr_done");
        check("wr_nwrites", wa_q.size(), 6);
        check("wr_addr0", wa_q[4], 32'hFFFF_FFFC);
        check("wr_addr1", wa_q[5], 32'h0000_0000);
        check("wr_data1", wd_q[5], 32'hCAFE_0002);

        // Reset while a request is stalled
        mem_delay = 1000;
        send_word(32'h0000_5000);
        send_word(32'h0000_0001);
        send_word(32'h0BAD_F00D);
        for (int i = 0; i < 50 && !bus.data_req_o; i++) @(negedge clk);
        check("mr_req_up", bus.data_req_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_req_dropped", bus.data_req_o, 0);
        check("mr_cpu_rst", cpu_rst, 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mr_nwrites", wa_q.size(), 6);
        check("mr_err", err_cnt, 1);
`ifndef UART_LOADER_ACK_EN
        check("tx_idle", tx_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
